// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg
// Shared encodings for the RV32M multiply/divide sequencer:
//   - funct3 encodings of the eight M-extension ops
//   - funct7 value that marks an OP instruction as an M-extension op
//   - 2-bit FSM state encodings
//   - small decode helpers for operand signedness
package ex_muldiv_ctrl_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] MD_IDLE = 2'b00;
  localparam logic [1:0] MD_CALC = 2'b01;
  localparam logic [1:0] MD_DONE = 2'b10;

  // rs1 is read as signed by every op except the fully unsigned ones
  function automatic logic op_signed_a(input logic [2:0] op);
    return !(op == MULDIV_MULHU || op == MULDIV_DIVU || op == MULDIV_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM (MULHSU reads it unsigned)
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MULDIV_MUL || op == MULDIV_MULH ||
            op == MULDIV_DIV || op == MULDIV_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_serial_divider.sv
// ex_muldiv_ctrl_serial_divider
// Unsigned restoring divider, one quotient bit per step. Operands are
// magnitudes; sign handling lives in the parent.
// Ports:
//   clk      in   clock
//   load     in   capture dividend/divisor, clear remainder
//   step     in   perform one restoring step
//   dividend in   XLEN dividend magnitude
//   divisor  in   XLEN divisor magnitude
//   quo_nxt  out  quotient after the step being taken this cycle
//   rem_nxt  out  remainder after the step being taken this cycle
module ex_muldiv_ctrl_serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
  logic [XLEN:0]   shifted, diff;

  // The partial remainder shifted left needs one guard bit. Because the
  // remainder is always below the divisor, bit XLEN of the difference is
  // set exactly when the trial subtraction borrows.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
    quo_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};
    rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dvsr_q <= divisor;
    end else if (step) begin
      quo_q  <= quo_nxt;
      rem_q  <= rem_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl
// EX-stage sequencer for RV32M ops: iterative shift-add multiplier,
// restoring divider (sub-module), sign fix-up and pipeline stall.
// Optional feature macro: EX_MULDIV_FAST_MUL_EN (single-cycle multiply).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       valid M-op in EX, not being flushed
//   op_i          funct3 of the M-op
//   operand_a_i   forwarded rs1      operand_b_i  forwarded rs2
//   rd_addr_i     destination register
//   flush_i       EX flush; aborts the current op
//   stall_o       freezes PC, IF/ID, ID/EX
//   busy_o        FSM not idle
//   done_o        one-cycle pulse, result_o valid
//   result_o      result, held until the next done
//   rd_addr_o     rd latched at start
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] sel_mul(input logic [2:0] op, input logic [2*XLEN-1:0] p);
    return (op == MULDIV_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic [1:0]        state, state_n;
  logic [4:0]        cnt;
  logic              done_q;
  logic              accept, a_neg, b_neg, div_zero, div_ovf, mul_fast, fast_done;
  logic [XLEN-1:0]   a_abs, b_abs, fast_res, calc_res, res_n;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt, mul_full;
  logic [XLEN:0]     add_sum;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;

  // Decode and fast-path detection in IDLE
  always_comb begin
    accept   = (state == MD_IDLE) && start_i && !flush_i;
    a_neg    = op_signed_a(op_i) && operand_a_i[XLEN-1];
    b_neg    = op_signed_b(op_i) && operand_b_i[XLEN-1];
    a_abs    = neg_w(operand_a_i, a_neg);
    b_abs    = neg_w(operand_b_i, b_neg);
    div_zero = op_i[2] && (operand_b_i == '0);
    div_ovf  = (op_i == MULDIV_DIV || op_i == MULDIV_REM) &&
               (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b_i == '1);
  end

`ifdef EX_MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fm_a, fm_b, fm_prod;
  assign fm_a     = {{XLEN{a_neg}}, operand_a_i};
  assign fm_b     = {{XLEN{b_neg}}, operand_b_i};
  assign fm_prod  = fm_a * fm_b;
  assign mul_full = fm_prod;
  assign mul_fast = !op_i[2];
`else
  assign mul_full = '0;
  assign mul_fast = 1'b0;
`endif

  always_comb begin
    fast_done = div_zero || div_ovf || mul_fast;
    if (mul_fast)      fast_res = sel_mul(op_i, mul_full);
    else if (div_zero) fast_res = op_i[1] ? operand_a_i : '1;
    else               fast_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Shift-add step: add the multiplicand when the current multiplier bit
  // (acc LSB) is set, then shift the 65-bit {carry, acc} right by one.
  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_nxt = {add_sum, acc_q[XLEN-1:1]};
  end

  ex_muldiv_ctrl_serial_divider #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .load     (accept),
    .step     ((state == MD_CALC) && op_q[2]),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // The last iteration and the sign fix-up share the DONE transition edge,
  // so the result is taken from the step values, not the registers.
  always_comb begin
    if (op_q[2]) calc_res = neg_w(op_q[1] ? rem_nxt : quo_nxt, neg_q);
    else         calc_res = sel_mul(op_q, neg_d(acc_nxt, neg_q));
    res_n = (state == MD_IDLE) ? fast_res : calc_res;
  end

  always_comb begin
    state_n = state;
    case (state)
      MD_IDLE: if (accept) state_n = fast_done ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (flush_i)       state_n = MD_IDLE;
        else if (cnt == 0) state_n = MD_DONE;
      end
      default: state_n = MD_IDLE;
    endcase
  end

  // Control stage: FSM, counter, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      done_q    <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else begin
      state  <= state_n;
      done_q <= (state_n == MD_DONE);
      if (accept) begin
        cnt       <= 5'd31;
        rd_addr_o <= rd_addr_i;
      end else if ((state == MD_CALC) && (cnt != 0)) begin
        cnt <= cnt - 5'd1;
      end
      if (state_n == MD_DONE) result_o <= res_n;
    end
  end

  // Datapath stage: operand capture and multiplier accumulator
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_i;
      neg_q   <= (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
      mcand_q <= a_abs;
      acc_q   <= {{XLEN{1'b0}}, b_abs};
    end else if (state == MD_CALC) begin
      acc_q   <= acc_nxt;
    end
  end

  // A flush or reset in the DONE cycle squashes the instruction being
  // retired, so the registered pulse is masked rather than delivered.
  assign done_o  = done_q && !flush_i && !rst;
  assign busy_o  = (state != MD_IDLE);
  assign stall_o = !rst && (accept || (state == MD_CALC));

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  ex_muldiv_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: RV32M semantics straight from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      OP_MUL:    begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      OP_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      OP_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef EX_MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int lat;
    exp_t e;
    lat = ref_lat(op, a, b);
    start_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b; rd_addr_i = rd;
    e.res = ref_result(op, a, b); e.rd = rd; e.cyc = cyc + lat;
    sb_q.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check("stall", {31'd0, stall_o}, {31'd0, k < lat});
      check("busy", {31'd0, busy_o}, {31'd0, k > 0});
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  // DIV -7/2 aborted by flush or reset in cycle 10.
  task automatic abort_div(input bit use_rst);
    start_i = 1'b1; op_i = OP_DIV; operand_a_i = 32'hFFFF_FFF9; operand_b_i = 32'd2;
    rd_addr_i = 5'd9;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) begin
        if (use_rst) rst = 1'b1;
        else         flush_i = 1'b1;
      end
      @(negedge clk);
      if (k == 10) check(use_rst ? "abort_rst_stall10" : "abort_flush_stall10",
                         {31'd0, stall_o}, {31'd0, !use_rst});
      @(posedge clk); #1;
    end
    rst = 1'b0; flush_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("abort_busy11", {31'd0, busy_o}, 32'd0);
    check("abort_stall11", {31'd0, stall_o}, 32'd0);
    if (use_rst) begin
      check("abort_rst_result", result_o, 32'd0);
      check("abort_rst_rd", {27'd0, rd_addr_o}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pairs every done_o pulse with the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_done: no done_o by cycle %0d, expected result %h", e.cyc, e.res);
      end
      if (done_o) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at cycle %0d: result %h, none expected", cyc, result_o);
        end else begin
          e = sb_q.pop_front();
          check("result", result_o, e.res);
          check("rd_addr", {27'd0, rd_addr_o}, {27'd0, e.rd});
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b1; flush_i = 1'b0; op_i = OP_MUL;
    operand_a_i = 32'd1; operand_b_i = 32'd1; rd_addr_i = 5'd5;
    @(negedge clk); @(negedge clk);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", {27'd0, rd_addr_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases, back to back
    issue(OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd1);
    issue(OP_MUL,    32'd12345,     32'd678,       5'd2);
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4);
    issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5);
    issue(OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd6);
    issue(OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd7);
    issue(OP_DIVU,   32'd100,       32'd7,         5'd8);
    issue(OP_REMU,   32'd100,       32'd7,         5'd9);
    issue(OP_DIVU,   32'd5,         32'd0,         5'd10);
    issue(OP_REM,    32'd5,         32'd0,         5'd11);
    issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

    abort_div(1'b0);
    abort_div(1'b1);
    repeat (3) begin @(posedge clk); #1; end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rnd_operand();
      b  = rnd_operand();
      issue(op, a, b, 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
